// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding and default widths.
package lsu_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WR_WB = 2'd2,
    S_WR_SB = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_store_fifo.sv
// Circular store buffer with wrap-bit pointers and an address match against
// every occupied entry, used to hold back loads that would bypass a store.
module lsu_store_fifo
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 2,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  input  logic [AW-1:0] query_addr,
  output logic          addr_hit
);

  localparam int PW = $clog2(SB_DEPTH);

  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] addr_q [SB_DEPTH];
  logic [AW-1:0] addr_d [SB_DEPTH];
  logic [DW-1:0] data_q [SB_DEPTH];
  logic [DW-1:0] data_d [SB_DEPTH];
  logic [PW:0]   count;
  logic [PW-1:0] offs;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign head_addr = addr_q[rd_ptr_q[PW-1:0]];
  assign head_data = data_q[rd_ptr_q[PW-1:0]];

  // An entry is occupied when its distance from the head is below the fill count.
  always_comb begin
    addr_hit = 1'b0;
    offs     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q[PW-1:0];
      if (({1'b0, offs} < count) && (addr_q[i] == query_addr)) addr_hit = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    // When full, a same-cycle pop vacates the head slot that the push then reuses.
    if (push && (!full || pop)) begin
      addr_d[wr_ptr_q[PW-1:0]] = push_addr;
      data_d[wr_ptr_q[PW-1:0]] = push_data;
      wr_ptr_d                 = wr_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit owning the 16-bit memory bus: issues AGU loads, buffers stores
// and writes back RMW results, keeping loads ordered behind matching writes.
//   state   | meaning
//   S_IDLE  | bus free, choose next transfer (WB > load > buffered store)
//   S_LOAD  | read in flight, waiting for bus_ack
//   S_WR_WB | RMW write-back in flight
//   S_WR_SB | store-buffer head write in flight
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int SB_DEPTH = 2
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          agu_valid,
  input  logic          agu_we,
  input  logic [AW-1:0] agu_addr,
  input  logic [DW-1:0] agu_wdata,
  output logic          agu_ready,
  input  logic          rmw_deny_op,
  input  logic          rmw_data_rdy,
  input  logic [AW-1:0] rmw_addr,
  input  logic [DW-1:0] rmw_data,
  output logic          lsu_ack,
  output logic          mem_rdy,
  output logic [DW-1:0] mem_data_in,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack
);

  lsu_state_e    state_q, state_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          mem_rdy_q, mem_rdy_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic          sb_full, sb_empty, sb_hit, sb_pop;
  logic [AW-1:0] sb_head_addr;
  logic [DW-1:0] sb_head_data;
  logic          ack_eff, store_acc, load_acc;

  lsu_store_fifo #(.SB_DEPTH(SB_DEPTH), .AW(AW), .DW(DW)) u_sb (
    .clk        (clk),
    .a_rst      (a_rst),
    .push       (store_acc),
    .push_addr  (agu_addr),
    .push_data  (agu_wdata),
    .pop        (sb_pop),
    .full       (sb_full),
    .empty      (sb_empty),
    .head_addr  (sb_head_addr),
    .head_data  (sb_head_data),
    .query_addr (agu_addr),
    .addr_hit   (sb_hit)
  );

  assign ack_eff   = bus_ack & bus_req_q;
  assign sb_pop    = (state_q == S_WR_SB) & ack_eff;
  assign lsu_ack   = rmw_data_rdy & ~wb_valid_q;
  assign store_acc = agu_valid & agu_we & ~rmw_deny_op & (~sb_full | sb_pop);
  // rmw_data_rdy gates loads so a capture this cycle is never overtaken.
  assign load_acc  = agu_valid & ~agu_we & ~rmw_deny_op & (state_q == S_IDLE) &
                     ~wb_valid_q & ~rmw_data_rdy & ~sb_hit;
  assign agu_ready = store_acc | load_acc;

  always_comb begin
    state_d     = state_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    mem_rdy_d   = 1'b0;
    mem_data_d  = mem_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (wb_valid_q) begin
          state_d     = S_WR_WB;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = wb_addr_q;
          bus_wdata_d = wb_data_q;
        end else if (load_acc) begin
          state_d    = S_LOAD;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = agu_addr;
        end else if (!sb_empty) begin
          state_d     = S_WR_SB;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = sb_head_addr;
          bus_wdata_d = sb_head_data;
        end
      end
      default: begin
        if (ack_eff) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          if (state_q == S_LOAD) begin
            mem_rdy_d  = 1'b1;
            mem_data_d = bus_rdata;
          end
          if (state_q == S_WR_WB) wb_valid_d = 1'b0;
        end
      end
    endcase
    if (lsu_ack) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = rmw_addr;
      wb_data_d  = rmw_data;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= S_IDLE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      mem_rdy_q   <= 1'b0;
      mem_data_q  <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      mem_rdy_q   <= mem_rdy_d;
      mem_data_q  <= mem_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign mem_rdy     = mem_rdy_q;
  assign mem_data_in = mem_data_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;

endmodule
